// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler for a shared 16:1 mux: picks one requester, drives the
// mux select and a one-hot grant, and bounds each grant with a hold limit.
module mux16_rr_sched #(
   parameter int NUM_CH   = 16,
   parameter int SEL_W    = 4,
   parameter int HOLD_MAX = 8,
   parameter int CNT_W    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] req,
   input  logic              done,
   output logic [SEL_W-1:0]  sel,
   output logic [NUM_CH-1:0] grant,
   output logic              valid,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;

   state_e              state_q, state_d;
   logic [SEL_W-1:0]    ptr_q, ptr_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [NUM_CH-1:0]   grant_q, grant_d;

   logic                found;
   logic [SEL_W-1:0]    winner;
   logic [SEL_W-1:0]    scan_idx;
   logic                hold_hit;
   logic                release_c;

   // Scan starts at ptr and wraps naturally through the SEL_W-bit adder.
   always_comb begin
      found    = 1'b0;
      winner   = ptr_q;
      scan_idx = ptr_q;
      for (int i = 0; i < NUM_CH; i++) begin
         scan_idx = ptr_q + SEL_W'(i);
         if (!found && req[scan_idx]) begin
            found  = 1'b1;
            winner = scan_idx;
         end
      end
   end

   assign hold_hit  = (HOLD_MAX != 0) && (cnt_q == CNT_W'(HOLD_MAX));
   assign release_c = done || !req[sel_q] || hold_hit;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
      end
   end

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      unique case (state_q)
         IDLE, GAP: begin
            if (found) begin
               state_d = GRANT;
               sel_d   = winner;
               grant_d = NUM_CH'(1) << winner;
               cnt_d   = CNT_W'(1);
            end else begin
               state_d = IDLE;
               grant_d = '0;
            end
         end
         GRANT: begin
            // sel is held through release so the mux input stays put.
            if (release_c) begin
               state_d = GAP;
               grant_d = '0;
               ptr_d   = sel_q + SEL_W'(1);
               cnt_d   = '0;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_comb begin
      sel   = sel_q;
      grant = grant_q;
      valid = (state_q == GRANT);
      busy  = (state_q != IDLE);
   end

endmodule
